nexys4_debounce: RTL
====================

NEXYS4_DEBOUNCE -- requirements
Module: nexys4_debounce

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 Parameter DEBOUNCE_TICKS, default 5, consecutive disagreeing ticks needed before a debounced output changes (range 2..15).
REQ-003 Parameter SIMULATE, default 0; when 1, TICK_DIV = 16, otherwise TICK_DIV = CLK_FREQ_HZ/1000 (1 ms tick).
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pbtn_in  in  6  raw pushbuttons: [5:1] = btnC, btnU, btnL, btnR, btnD (active high); [0] = CPU-reset button (active low).
REQ-007 swtch_in  in  16  raw slide switches, active high.
REQ-008 db_btns  out  6  debounced pushbuttons, all active high; bit 0 is the inverted CPU-reset button.
REQ-009 db_sw  out  16  debounced slide switches.
REQ-010 btn_rise  out  6  one-clock pulse per bit when db_btns bit goes 0->1.
REQ-011 tick  out  1  one-clock prescaler pulse, exported for neighbouring timers.

Function
REQ-012 pbtn_in[0] SHALL be inverted before synchronisation so that all 22 channels are processed as active high.
REQ-013 Each of the 22 channels SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-015 Each channel SHALL own a 4-bit stability counter that updates only in tick cycles.
REQ-016 In a tick cycle, a sync bit equal to its debounced output SHALL clear that channel's counter.
REQ-017 In a tick cycle, a mismatching sync bit SHALL increment the counter.
REQ-018 When the increment would reach DEBOUNCE_TICKS, the debounced output SHALL toggle on that edge and the counter SHALL clear.
REQ-019 A mismatch lasting fewer than DEBOUNCE_TICKS consecutive ticks SHALL leave the output unchanged.
REQ-020 Latency from a stable raw edge to the debounced output SHALL be between 2+(DEBOUNCE_TICKS-1)*TICK_DIV+1 and 2+DEBOUNCE_TICKS*TICK_DIV clocks.
REQ-021 btn_rise[i] SHALL be high for exactly the cycle after db_btns[i] rises and SHALL never assert on a falling edge.
REQ-022 Channels SHALL be independent, so simultaneous changes on several bits each obey REQ-016..REQ-019 separately.
REQ-023 Counters SHALL saturate logically: no wrap-around can occur, because the clear at DEBOUNCE_TICKS precedes the 4-bit limit.

Reset
REQ-024 Asserting reset SHALL immediately clear the synchronisers, prescaler, stability counters, db_btns, db_sw, btn_rise and tick, regardless of clock.
REQ-025 Reset asserted mid-count SHALL discard any partial debounce, so the first output change after release again needs a full DEBOUNCE_TICKS ticks.
REQ-026 The prescaler SHALL restart at 0 on reset release, so the first tick occurs TICK_DIV clocks after release.

Structure
REQ-027 TICK_DIV derivation, counter width and button bit-index constants (BTN_C..BTN_D, BTN_CPU_RST) SHALL live in a shared package used by this block and by the PicoBlaze I/O interface.
REQ-028 One sub-module, debounce_chan (synchroniser, counter, output flop for one bit), SHALL be instantiated 22 times via generate; the prescaler stays in the top level.

Verification (SIMULATE=1, TICK_DIV=16, DEBOUNCE_TICKS=4)
REQ-029 Stable press: pbtn_in[1] 0->1 held -> db_btns[1] rises between 51 and 66 clocks later, and btn_rise[1] pulses once for 1 clock.
REQ-030 Bounce: swtch_in[3] toggles 1 for 30 clocks then returns to 0 -> db_sw[3] stays 0 throughout.
REQ-031 Reset button: pbtn_in[0] driven 1->0 and held -> db_btns[0] rises within 66 clocks; on release the bit falls after the same window and btn_rise[0] stays 0 on the fall.
REQ-032 Simultaneous change: swtch_in = 16'hFFFF at one edge -> all db_sw bits change on the same clock, and db_sw = 16'hFFFF.
REQ-033 Reset mid-operation: raise swtch_in[0], assert reset 40 clocks later for 3 clocks -> all outputs read 0 during reset, and db_sw[0] rises between 64 and 66 clocks after release.
REQ-034 Tick check: free run for 160 clocks after reset -> exactly 10 tick pulses, the first 16 clocks after release.

Source files
------------

// File: rtl/nexys4_debounce_pkg.sv
// Shared constants for the Nexys4 button/switch debouncer and the PicoBlaze I/O map.
// Bit positions below describe how the pushbuttons are packed into db_btns.
package nexys4_debounce_pkg;

    localparam int CNT_W        = 4;
    localparam int NUM_BTN      = 6;
    localparam int NUM_SW       = 16;
    localparam int NUM_CHAN     = NUM_BTN + NUM_SW;
    localparam int SIM_TICK_DIV = 16;

    localparam int BTN_CPU_RST = 0;
    localparam int BTN_D       = 1;
    localparam int BTN_R       = 2;
    localparam int BTN_L       = 3;
    localparam int BTN_U       = 4;
    localparam int BTN_C       = 5;

    typedef struct packed {
        logic [NUM_SW-1:0]  sw;
        logic [NUM_BTN-1:0] btn;
    } chan_vec_t;

    // Simulation uses a short prescaler so debounce windows stay a few dozen clocks long.
    function automatic int calc_tick_div(input int simulate, input int clk_freq_hz);
        return (simulate != 0) ? SIM_TICK_DIV : clk_freq_hz / 1000;
    endfunction

endpackage

// File: rtl/nexys4_debounce_chan.sv
// One debounced channel: 2-flop synchroniser, tick-qualified stability counter
// and the debounced output flop.
module debounce_chan
    import nexys4_debounce_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic db_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             meta_q;
    logic             sync_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The clear on the final increment keeps the counter below DEBOUNCE_TICKS, so it never wraps.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (tick_i) begin
            if (sync_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/nexys4_debounce.sv
// Debouncer for the Nexys4 pushbuttons and slide switches: shared 1 ms prescaler
// feeding 22 independent debounce channels, plus rising-edge pulses for the buttons.
module nexys4_debounce
    import nexys4_debounce_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int SIMULATE       = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  pbtn_in,
    input  logic [NUM_SW-1:0]   swtch_in,
    output logic [NUM_BTN-1:0]  db_btns,
    output logic [NUM_SW-1:0]   db_sw,
    output logic [NUM_BTN-1:0]  btn_rise,
    output logic                tick
);

    localparam int TICK_DIV = calc_tick_div(SIMULATE, CLK_FREQ_HZ);
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]      presc_q;
    logic [PW-1:0]      presc_d;
    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] raw_btn;
    chan_vec_t          raw_s;
    chan_vec_t          db_s;
    logic [NUM_CHAN-1:0] raw_vec;
    logic [NUM_CHAN-1:0] db_vec;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (tick) begin
            presc_d = '0;
        end
    end

    // CPU-reset button is active low on the board; flip it so every channel is active high.
    always_comb begin
        raw_btn              = pbtn_in;
        raw_btn[BTN_CPU_RST] = ~pbtn_in[BTN_CPU_RST];
    end

    assign raw_s.btn = raw_btn;
    assign raw_s.sw  = swtch_in;
    assign raw_vec   = raw_s;

    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .tick_i (tick),
            .raw_i  (raw_vec[gi]),
            .db_o   (db_vec[gi])
        );
    end

    assign db_s    = db_vec;
    assign db_btns = db_s.btn;
    assign db_sw   = db_s.sw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            btn_prev_q <= '0;
        end else begin
            presc_q    <= presc_d;
            btn_prev_q <= db_btns;
        end
    end

    assign btn_rise = db_btns & ~btn_prev_q;

endmodule
